ram_dma: RTL and testbench
==========================

Name: ram_dma

Overview:
- Bus initiator for the single-port RAM word interface (cyc/we/sel/addr/wdata/rdata). It drives the RAM side rather than responding to it.
- Copies a block of LEN 32-bit words from a source word address to a destination word address. The work is started by a control pulse from the CPU-side register block.
- Sits between the SoC register file and the RAM bus arbiter. It issues one read, then one full-word write, per word.

Parameters:
- ADDR_W, 22, width of word address driven on the RAM bus (upper addr bits tied 0).
- LEN_W, 16, width of length/count registers.
- RD_LAT, 1, cycles from read address presented (cyc=1, we=0) to rdata valid; the RAM read is registered.

Ports:
- ck  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; latches src/dst/len when idle.
- abort  input  1  stop transfer; takes priority over normal progress.
- src  input  ADDR_W  source word address.
- dst  input  ADDR_W  destination word address.
- len  input  LEN_W  number of words to copy.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle pulse on normal completion.
- remaining  output  LEN_W  words not yet written.
- cyc  output  1  bus cycle active.
- we  output  1  write enable.
- sel  output  4  byte lanes; 4'hF on writes, 4'h0 otherwise.
- addr  output  32  word address, zero-extended from ADDR_W.
- wdata  output  32  write data.
- rdata  input  32  read data; valid only while cyc=1.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - busy, done, cyc, we = 0; sel = 0; addr, wdata = 0; remaining = 0.
  - Internal src/dst/count/buffer registers = 0.
- States: IDLE, RD, RD_WAIT, WR, FINISH.
- IDLE:
  - Bus outputs 0.
  - On start with len != 0: latch src/dst/len, remaining = len, busy = 1, go to RD.
  - On start with len == 0: go to FINISH directly with no bus activity.
- RD:
  - cyc=1, we=0, sel=0, addr=src_cur.
  - Next state RD_WAIT. A wait counter is loaded with RD_LAT-1.
- RD_WAIT:
  - Hold cyc=1, we=0, addr=src_cur, because the RAM gates rdata with cyc.
  - When the wait counter reaches 0, capture rdata into the word buffer and go to WR.
  - With RD_LAT=1 this state lasts exactly one cycle.
- WR:
  - cyc=1, we=1, sel=4'hF, addr=dst_cur, wdata=buffer; writes take one cycle.
  - Then src_cur+1, dst_cur+1, remaining-1.
  - If remaining was 1, go to FINISH; otherwise go to RD.
- FINISH: done=1 for exactly this cycle, busy=0 on exit, cyc=0, then IDLE.
- Throughput: RD_LAT+2 cycles per word; 3 cycles with defaults.
- Latency from start to first cyc: 1 cycle.
- Overlap: forward copy only, ascending addresses. Overlapping regions with dst > src corrupt the source by design; software avoids this.
- Address wrap: src_cur/dst_cur wrap modulo 2^ADDR_W with no error.
- start while busy: ignored; latched values unchanged.
- abort:
  - In any non-IDLE state, the next state is IDLE and cyc/we/sel drop the next cycle.
  - done is not pulsed; remaining holds the unfinished count.
  - A write already presented in the abort cycle completes (it is on the bus that cycle).
  - abort with start in IDLE: start ignored.
- rdata is ignored outside RD_WAIT.

Optional Feature:
- Macro: RAM_DMA_FILL_EN.
- With it: extra input ports fill (1) and pattern (32).
  - If fill=1 at start, the RD/RD_WAIT states are skipped: WR writes pattern to successive dst words.
  - Costs 1 cycle per word; src is ignored.
- Without it: ports absent, copy only.

Decomposition:
- Package ram_dma_pkg: state enum (IDLE, RD, RD_WAIT, WR, FINISH), SEL_ALL=4'hF constant, default width constants.
- No sub-module needed; a single FSM with datapath registers. The wait counter stays inline.

Test Plan:
- Copy 4 words from src=0x100 to dst=0x200, RAM preloaded 0xA0..0xA3.
  - Expect dst words 0xA0..0xA3.
  - done pulse at cycle 1+12, exactly once.
  - busy high for 12 cycles.
- len=0 start: no cyc asserted; done one cycle after start; remaining=0.
- start pulsed again mid-transfer with different src/dst/len: ignored; original copy completes unchanged.
- abort asserted in the WR of word 2 of 5:
  - Word 2 is written; words 3-5 are untouched.
  - remaining=3, no done pulse; cyc=0 next cycle.
- rst_n dropped asynchronously during RD_WAIT:
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, a new start with len=1 works.
- (RAM_DMA_FILL_EN) fill=1, pattern=0xDEADBEEF, dst=0x10, len=3.
  - Words 0x10..0x12 = 0xDEADBEEF.
  - No read cycles (we=1 on every cyc cycle); done after 4 cycles.

Source files
------------

// File: rtl/ram_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_dma_pkg
// Desc     : Shared state encoding, byte-lane and width defaults for ram_dma.
// Revision : 1.0 - initial release
// ============================================================================
package ram_dma_pkg;

  localparam int ADDR_W_DEF = 22;
  localparam int LEN_W_DEF  = 16;
  localparam int RD_LAT_DEF = 1;

  localparam logic [3:0] SEL_ALL = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR      = 3'd3,
    S_FINISH  = 3'd4
  } state_e;

  // Plain-vector aliases so the FSM register stays a simple logic vector.
  localparam logic [2:0] ST_IDLE    = S_IDLE;
  localparam logic [2:0] ST_RD      = S_RD;
  localparam logic [2:0] ST_RD_WAIT = S_RD_WAIT;
  localparam logic [2:0] ST_WR      = S_WR;
  localparam logic [2:0] ST_FINISH  = S_FINISH;

endpackage : ram_dma_pkg
`default_nettype wire

// File: rtl/ram_dma_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_dma_if
// Desc     : Single-port RAM word bus (cyc/we/sel/addr/wdata/rdata).
// Revision : 1.0 - initial release
// ============================================================================
interface ram_dma_if;

  logic        cyc;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output cyc,
    output we,
    output sel,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  cyc,
    input  we,
    input  sel,
    input  addr,
    input  wdata,
    output rdata
  );

endinterface : ram_dma_if
`default_nettype wire

// File: rtl/ram_dma.sv
`default_nettype none
// ============================================================================
// Module   : ram_dma
// Desc     : Word-copy DMA initiator on the RAM bus: one read then one
//            full-word write per word, ascending addresses.
// Options  : RAM_DMA_FILL_EN adds fill/pattern ports for pattern fill.
// Revision : 1.0 - initial release
// ============================================================================
module ram_dma
  import ram_dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              ck,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
`ifdef RAM_DMA_FILL_EN
  input  logic              fill,
  input  logic [31:0]       pattern,
`endif
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  remaining,
  ram_dma_if.master         bus
);

  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RD_LAT - 1);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_src_cur;
  logic [ADDR_W-1:0] r_dst_cur;
  logic [LEN_W-1:0]  r_rem;
  logic [31:0]       r_buf;
  logic [WAIT_W-1:0] r_wait;
`ifdef RAM_DMA_FILL_EN
  logic              r_fill;
`endif

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_src_cur <= '0;
      r_dst_cur <= '0;
      r_rem     <= '0;
      r_buf     <= '0;
      r_wait    <= '0;
`ifdef RAM_DMA_FILL_EN
      r_fill    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          // abort alongside start cancels the request outright
          if (start && !abort) begin
            r_src_cur <= src;
            r_dst_cur <= dst;
            r_rem     <= len;
            if (len == '0) begin
              r_state <= ST_FINISH;
            end else begin
`ifdef RAM_DMA_FILL_EN
              r_fill <= fill;
              if (fill) begin
                r_buf   <= pattern;
                r_state <= ST_WR;
              end else begin
                r_state <= ST_RD;
              end
`else
              r_state <= ST_RD;
`endif
            end
          end
        end

        ST_RD: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else begin
            r_wait  <= WAIT_LOAD;
            r_state <= ST_RD_WAIT;
          end
        end

        ST_RD_WAIT: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (r_wait == '0) begin
            r_buf   <= bus.rdata;
            r_state <= ST_WR;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end

        ST_WR: begin
          // The write is on the bus this cycle, so it counts even under abort.
          r_src_cur <= r_src_cur + 1'b1;
          r_dst_cur <= r_dst_cur + 1'b1;
          r_rem     <= r_rem - 1'b1;
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (r_rem == LEN_W'(1)) begin
            r_state <= ST_FINISH;
          end else begin
`ifdef RAM_DMA_FILL_EN
            r_state <= r_fill ? ST_WR : ST_RD;
`else
            r_state <= ST_RD;
`endif
          end
        end

        ST_FINISH: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Bus outputs decode straight from state so reset clears them immediately.
  always_comb begin
    bus.cyc   = 1'b0;
    bus.we    = 1'b0;
    bus.sel   = 4'h0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    case (r_state)
      ST_RD, ST_RD_WAIT: begin
        bus.cyc  = 1'b1;
        bus.addr = 32'(r_src_cur);
      end
      ST_WR: begin
        bus.cyc   = 1'b1;
        bus.we    = 1'b1;
        bus.sel   = SEL_ALL;
        bus.addr  = 32'(r_dst_cur);
        bus.wdata = r_buf;
      end
      default: begin
        bus.cyc = 1'b0;
      end
    endcase
  end

  always_comb begin
    busy      = (r_state == ST_RD) || (r_state == ST_RD_WAIT) || (r_state == ST_WR);
    done      = (r_state == ST_FINISH);
    remaining = r_rem;
  end

endmodule : ram_dma
`default_nettype wire

// File: tb/tb_ram_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_dma
// Desc     : Self-checking bench for ram_dma (copy build) with a RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_dma;

  localparam int AW = 22;
  localparam int LW = 16;
  localparam int MW = 1024;

  logic          ck = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic [LW-1:0] remaining;

  ram_dma_if bus ();

  ram_dma #(.ADDR_W(AW), .LEN_W(LW), .RD_LAT(1)) dut (
    .ck        (ck),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .remaining (remaining),
    .bus       (bus.master)
  );

  always #5 ck = ~ck;

  // RAM model: registered read, rdata gated by cyc; mem index aliases mod MW.
  logic [31:0] mem [0:MW-1];
  logic [31:0] exp_mem [0:MW-1];
  logic [31:0] rd_q;
  logic        ld;
  logic [9:0]  ld_a;
  logic [31:0] ld_d;

  always @(posedge ck) begin
    if (ld) mem[ld_a] <= ld_d;
    else if (bus.cyc && bus.we && bus.sel == 4'hF) mem[bus.addr[9:0]] <= bus.wdata;
    if (bus.cyc && !bus.we) rd_q <= mem[bus.addr[9:0]];
  end
  assign bus.rdata = bus.cyc ? rd_q : 32'h0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [AW-1:0] s;
    logic [AW-1:0] d;
    logic [LW-1:0] n;
    int            ab;      // cycle of abort pulse, 0 = none
    int            rs;      // cycle of spurious restart, 0 = none
    int            e_done;  // cycle of done pulse, -1 = none
    int            e_busy;
    int            e_rd;
    int            e_wr;
    logic [LW-1:0] e_rem;
  } vec_t;

  function automatic logic [31:0] init_val(input int i);
    if (i >= 'h100 && i <= 'h103) return 32'hA0 + 32'(i - 'h100);
    return {16'hBEE0 ^ 16'(i), 16'(i * 3)};
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Forward copy of k words with addresses wrapping at 2^AW.
  task automatic model_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int k);
    for (int j = 0; j < k; j++) begin
      logic [AW-1:0] sa, da;
      sa = s + AW'(j);
      da = d + AW'(j);
      exp_mem[da[9:0]] = exp_mem[sa[9:0]];
    end
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    for (int i = 0; i < MW; i++) if (mem[i] !== exp_mem[i]) bad++;
    check(name, bad, 0);
  endtask

  // Called right after a negedge; that cycle is cycle 0 (start presented).
  task automatic run_xfer(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [LW-1:0] n, input int ab, input int rs,
                          output int done_c, output int ndone, output int nbusy,
                          output int nrd, output int nwr, output int selerr,
                          output logic [LW-1:0] rem_final);
    int win;
    src = s; dst = d; len = n; start = 1'b1; abort = 1'b0;
    done_c = -1; ndone = 0; nbusy = 0; nrd = 0; nwr = 0; selerr = 0;
    win = 3 * int'(n) + 5;
    for (int c = 1; c <= win; c++) begin
      @(negedge ck);
      start = (c == rs);
      if (c == rs) begin src = 22'h10; dst = 22'h20; len = 16'd2; end
      abort = (c == ab);
      if (busy) nbusy++;
      if (done) begin ndone++; if (done_c < 0) done_c = c; end
      if (bus.cyc && !bus.we) nrd++;
      if (bus.cyc && bus.we) nwr++;
      if (bus.sel != ((bus.cyc && bus.we) ? 4'hF : 4'h0)) selerr++;
    end
    start = 1'b0; abort = 1'b0;
    rem_final = remaining;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int dc, nd, nb, nr, nw, se, k;
    logic [LW-1:0] rf;
    run_xfer(v.s, v.d, v.n, v.ab, v.rs, dc, nd, nb, nr, nw, se, rf);
    k = (v.ab > 0) ? v.ab / 3 : int'(v.n);
    model_copy(v.s, v.d, k);
    check({tag, ".done_cyc"}, dc, v.e_done);
    check({tag, ".done_cnt"}, nd, (v.e_done < 0) ? 0 : 1);
    check({tag, ".busy_cyc"}, nb, v.e_busy);
    check({tag, ".rd_cyc"}, nr, v.e_rd);
    check({tag, ".wr_cyc"}, nw, v.e_wr);
    check({tag, ".sel"}, se, 0);
    check({tag, ".remaining"}, rf, v.e_rem);
    check_mem({tag, ".mem"});
  endtask

  vec_t tbl [10];

  initial begin
    int dc, nd, nb, nr, nw, se;
    logic [LW-1:0] rf;
    vec_t rv;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    src = '0; dst = '0; len = '0;
    ld = 1'b1; ld_a = '0; ld_d = '0;

    tbl[0] = '{22'h100,    22'h200,    16'd4, 0, 0, 13, 12,  8, 4, 16'd0};
    tbl[1] = '{22'h300,    22'h340,    16'd5, 0, 4, 16, 15, 10, 5, 16'd0};
    tbl[2] = '{22'h180,    22'h1C0,    16'd5, 6, 0, -1,  6,  4, 2, 16'd3};
    tbl[3] = '{22'h3FFFFE, 22'h240,    16'd4, 0, 0, 13, 12,  8, 4, 16'd0};
    tbl[4] = '{22'h060,    22'h3FFFFF, 16'd3, 0, 0, 10,  9,  6, 3, 16'd0};
    tbl[5] = '{22'h020,    22'h028,    16'd1, 0, 0,  4,  3,  2, 1, 16'd0};
    tbl[6] = '{22'h0A0,    22'h0B0,    16'd3, 1, 0, -1,  1,  1, 0, 16'd3};
    tbl[7] = '{22'h0C0,    22'h0D0,    16'd0, 0, 0,  1,  0,  0, 0, 16'd0};
    tbl[8] = '{22'h0E0,    22'h0F0,    16'd3, 9, 0, -1,  9,  6, 3, 16'd0};
    tbl[9] = '{22'h140,    22'h150,    16'd2, 2, 0, -1,  2,  2, 0, 16'd2};

    for (int i = 0; i < MW; i++) begin
      @(negedge ck);
      ld_a = 10'(i); ld_d = init_val(i); exp_mem[i] = init_val(i);
    end
    @(negedge ck);
    ld = 1'b0;

    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.remaining", remaining, 0);
    check("rst.cyc", bus.cyc, 0);
    check("rst.we", bus.we, 0);
    check("rst.sel", bus.sel, 0);
    check("rst.addr", bus.addr, 0);
    check("rst.wdata", bus.wdata, 0);
    rst_n = 1'b1;
    @(negedge ck);

    for (int i = 0; i < 10; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
      if (i == 0)
        for (int j = 0; j < 4; j++)
          check($sformatf("vec0.dst%0d", j), mem['h200 + j], 32'hA0 + 32'(j));
    end

    // Asynchronous reset in RD_WAIT of the first word.
    src = 22'h300; dst = 22'h380; len = 16'd3; start = 1'b1;
    @(negedge ck); start = 1'b0;
    @(negedge ck);
    check("arst.pre_cyc", bus.cyc, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst.busy", busy, 0);
    check("arst.cyc", bus.cyc, 0);
    check("arst.addr", bus.addr, 0);
    check("arst.remaining", remaining, 0);
    @(negedge ck); rst_n = 1'b1;
    @(negedge ck);
    rv = '{22'h310, 22'h390, 16'd1, 0, 0, 4, 3, 2, 1, 16'd0};
    run_vec(rv, "arst_len1");

    // abort together with start in IDLE: nothing happens.
    src = 22'h50; dst = 22'h70; len = 16'd4; start = 1'b1; abort = 1'b1;
    nb = 0; nd = 0; nr = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge ck); start = 1'b0; abort = 1'b0;
      if (busy) nb++;
      if (done) nd++;
      if (bus.cyc) nr++;
    end
    check("idle_abort.busy", nb, 0);
    check("idle_abort.done", nd, 0);
    check("idle_abort.cyc", nr, 0);
    check_mem("idle_abort.mem");

    // Random transfers against arithmetic expectations and the copy model.
    for (int t = 0; t < 12; t++) begin
      int n, ab;
      n  = int'($urandom_range(1, 12));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3 * n)) : 0;
      rv.s  = AW'($urandom);
      rv.d  = AW'($urandom);
      rv.n  = LW'(n);
      rv.ab = ab;
      rv.rs = 0;
      if (ab > 0) begin
        rv.e_done = -1;       rv.e_busy = ab;
        rv.e_rd   = ab - ab / 3; rv.e_wr = ab / 3;
        rv.e_rem  = LW'(n - ab / 3);
      end else begin
        rv.e_done = 3 * n + 1; rv.e_busy = 3 * n;
        rv.e_rd   = 2 * n;     rv.e_wr   = n;
        rv.e_rem  = '0;
      end
      run_vec(rv, $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_ram_dma
`default_nettype wire
